// File: rtl/sram_port_pkg.sv
// Shared types and helpers for the SRAM port controller.
//   state_e       controller FSM state (StInit, StRun)
//   mask_width    byte-enable width for a given data width (top lane may be partial)
//   mask_to_wbeb  expand active-high byte enables into active-low per-bit write enables
//   Tie*          values for the macro's static control pins
package sram_port_pkg;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Widest macro the expansion helper supports; callers size-cast the result.
  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxMaskWidth = MaxDataWidth / 8;

  localparam logic       TieMcen     = 1'b0;
  localparam logic [2:0] TieMc       = 3'b000;
  localparam logic [1:0] TieWa       = 2'b00;
  localparam logic [1:0] TieWpulse   = 2'b00;
  localparam logic       TieWpulseen = 1'b0;
  localparam logic       TieFwen     = 1'b0;
  localparam logic       TieClkbyp   = 1'b0;

  function automatic int unsigned mask_width(int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

  // Bit b is enabled (driven low) when byte lane b/8 is enabled.
  function automatic logic [MaxDataWidth-1:0] mask_to_wbeb(logic [MaxMaskWidth-1:0] mask);
    logic [MaxDataWidth-1:0] wbeb;
    for (int unsigned b = 0; b < MaxDataWidth; b++) begin
      wbeb[b] = ~mask[b / 8];
    end
    return wbeb;
  endfunction

endpackage

// File: rtl/sram_port_resp_fifo.sv
// Synchronous FIFO holding read responses until the consumer accepts them.
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    enqueue; ignored when full unless a pop happens in the same cycle
//   pop            dequeue head; ignored when empty
//   valid, rdata   head entry (rdata reads zero when empty)
//   count          current number of entries
module sram_port_resp_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((32'(count_q) < DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid = (count_q != '0);
  assign rdata = valid ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Host-side initiator for a single-port SRAM macro.
//   clk, rst                     clock, synchronous active-high reset
//   req_*                        valid/ready word read/write requests (wmask active-high bytes)
//   resp_*                       read responses in request order (err = address out of range)
//   init_done                    high once requests are being accepted
//   sram_adr/din/ren/wen/wbeb    registered macro access pins (wbeb active-low)
//   sram_q                       macro read data, valid the cycle after ren
//   sram_mcen..sram_clkbyp       static pins, tied low
// Build option: define SRAM_PORT_INIT_EN to zero the whole macro after every reset.
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned RESP_DEPTH = 4,
  localparam int unsigned MASK_W    = mask_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_W-1:0]     req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_ren,
  output logic                  sram_wen,
  output logic [DATA_WIDTH-1:0] sram_wbeb,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  sram_mcen,
  output logic [2:0]            sram_mc,
  output logic [1:0]            sram_wa,
  output logic [1:0]            sram_wpulse,
  output logic                  sram_wpulseen,
  output logic                  sram_fwen,
  output logic                  sram_clkbyp
);

  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  state_e                state_q;
  logic                  init_done_q;
  logic                  sram_ren_q, sram_wen_q;
  logic [ADDR_WIDTH-1:0] sram_adr_q;
  logic [DATA_WIDTH-1:0] sram_din_q, sram_wbeb_q;
  // Read pipeline: p1 = pins driven, p2 = macro output valid (captured into the FIFO).
  logic                  rd_p1_q, err_p1_q, rd_p2_q, err_p2_q;
`ifdef SRAM_PORT_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr_q;
`endif

  logic [CntW-1:0]       fifo_count;
  logic [1:0]            reads_inflight;
  logic                  accept, in_range, fifo_valid;
  logic [DATA_WIDTH:0]   push_data, fifo_rdata;

  // Every read in flight has a FIFO slot reserved, so a push never meets a full FIFO.
  assign reads_inflight = {1'b0, rd_p1_q} + {1'b0, rd_p2_q};
  assign req_ready = init_done_q && ((32'(fifo_count) + 32'(reads_inflight)) < RESP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_PORT_INIT_EN
      state_q     <= StInit;
      init_addr_q <= '0;
`else
      state_q     <= StRun;
`endif
      init_done_q <= 1'b0;
      sram_ren_q  <= 1'b0;
      sram_wen_q  <= 1'b0;
      sram_adr_q  <= '0;
      sram_din_q  <= '0;
      sram_wbeb_q <= '1;
      rd_p1_q     <= 1'b0;
      err_p1_q    <= 1'b0;
      rd_p2_q     <= 1'b0;
      err_p2_q    <= 1'b0;
    end else begin
      sram_ren_q  <= 1'b0;
      sram_wen_q  <= 1'b0;
      sram_wbeb_q <= '1;
      rd_p1_q     <= 1'b0;
      err_p1_q    <= 1'b0;
      rd_p2_q     <= rd_p1_q;
      err_p2_q    <= err_p1_q;
      init_done_q <= (state_q == StRun);
      case (state_q)
        StInit: begin
`ifdef SRAM_PORT_INIT_EN
          sram_wen_q  <= 1'b1;
          sram_adr_q  <= init_addr_q;
          sram_din_q  <= '0;
          sram_wbeb_q <= '0;
          init_addr_q <= init_addr_q + 1'b1;
          if (32'(init_addr_q) == DEPTH - 1) begin
            state_q <= StRun;
          end
`else
          state_q <= StRun;
`endif
        end
        StRun: begin
          if (accept) begin
            if (req_write) begin
              // Out-of-range writes are dropped without touching the pins.
              if (in_range) begin
                sram_wen_q  <= 1'b1;
                sram_adr_q  <= req_addr;
                sram_din_q  <= req_wdata;
                sram_wbeb_q <= DATA_WIDTH'(mask_to_wbeb(MaxMaskWidth'(req_wmask)));
              end
            end else begin
              // Out-of-range reads still occupy a pipeline slot to keep response order.
              rd_p1_q  <= 1'b1;
              err_p1_q <= !in_range;
              if (in_range) begin
                sram_ren_q <= 1'b1;
                sram_adr_q <= req_addr;
              end
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign push_data = {err_p2_q, err_p2_q ? '0 : sram_q};

  sram_port_resp_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rd_p2_q),
    .wdata(push_data),
    .pop  (resp_ready),
    .valid(fifo_valid),
    .rdata(fifo_rdata),
    .count(fifo_count)
  );

  assign resp_valid = fifo_valid;
  assign resp_err   = fifo_rdata[DATA_WIDTH];
  assign resp_rdata = fifo_rdata[DATA_WIDTH-1:0];
  assign init_done  = init_done_q;

  assign sram_adr  = sram_adr_q;
  assign sram_din  = sram_din_q;
  assign sram_ren  = sram_ren_q;
  assign sram_wen  = sram_wen_q;
  assign sram_wbeb = sram_wbeb_q;

  assign sram_mcen     = TieMcen;
  assign sram_mc       = TieMc;
  assign sram_wa       = TieWa;
  assign sram_wpulse   = TieWpulse;
  assign sram_wpulseen = TieWpulseen;
  assign sram_fwen     = TieFwen;
  assign sram_clkbyp   = TieClkbyp;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl: a 512x64 instance backed by a behavioural
// macro model, plus a 16x44 instance used to check the partial top byte lane.
module tb_sram_port_ctrl;

  localparam int unsigned AW = 10, DW = 64, DEP = 512, RD = 4, MW = 8;
  localparam int unsigned NAW = 4, NDW = 44, NMW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid, resp_ready, resp_err, init_done;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_din, sram_wbeb, sram_q;
  logic          sram_ren, sram_wen;
  logic          sram_mcen, sram_wpulseen, sram_fwen, sram_clkbyp;
  logic [2:0]    sram_mc;
  logic [1:0]    sram_wa, sram_wpulse;

  sram_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .init_done(init_done),
    .sram_adr(sram_adr), .sram_din(sram_din), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_wbeb(sram_wbeb), .sram_q(sram_q),
    .sram_mcen(sram_mcen), .sram_mc(sram_mc), .sram_wa(sram_wa), .sram_wpulse(sram_wpulse),
    .sram_wpulseen(sram_wpulseen), .sram_fwen(sram_fwen), .sram_clkbyp(sram_clkbyp)
  );

  logic           n_req_valid, n_req_ready, n_req_write;
  logic [NAW-1:0] n_req_addr, n_sram_adr;
  logic [NDW-1:0] n_req_wdata, n_resp_rdata, n_sram_din, n_sram_wbeb, n_sram_q;
  logic [NMW-1:0] n_req_wmask;
  logic           n_resp_valid, n_resp_err, n_init_done, n_sram_ren, n_sram_wen;
  logic           n_mcen, n_wpulseen, n_fwen, n_clkbyp;
  logic [2:0]     n_mc;
  logic [1:0]     n_wa, n_wpulse;

  assign n_sram_q = '0;

  sram_port_ctrl #(
    .ADDR_WIDTH(NAW), .DATA_WIDTH(NDW), .RESP_DEPTH(RD)
  ) dut_n (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(n_req_write),
    .req_addr(n_req_addr), .req_wdata(n_req_wdata), .req_wmask(n_req_wmask),
    .resp_valid(n_resp_valid), .resp_ready(1'b1), .resp_rdata(n_resp_rdata),
    .resp_err(n_resp_err), .init_done(n_init_done),
    .sram_adr(n_sram_adr), .sram_din(n_sram_din), .sram_ren(n_sram_ren),
    .sram_wen(n_sram_wen), .sram_wbeb(n_sram_wbeb), .sram_q(n_sram_q),
    .sram_mcen(n_mcen), .sram_mc(n_mc), .sram_wa(n_wa), .sram_wpulse(n_wpulse),
    .sram_wpulseen(n_wpulseen), .sram_fwen(n_fwen), .sram_clkbyp(n_clkbyp)
  );

  // Behavioural macro: masked write, registered read data.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (sram_wen) mem[sram_adr] <= (mem[sram_adr] & sram_wbeb) | (sram_din & ~sram_wbeb);
    if (sram_ren) sram_q <= mem[sram_adr];
  end

`ifdef SRAM_PORT_INIT_EN
  localparam int InitLat = DEP + 1;
`else
  localparam int InitLat = 1;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h00001000 * 32'(i + 1)};
  endfunction

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
    while (!req_ready && n < 20) begin step(); n++; end
    check("req_ready_before_issue", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Called one cycle after accept; a response must appear on the third cycle.
  task automatic await_resp(input string tag, input logic exp_resp, input logic [DW-1:0] exp_d,
                            input logic exp_e);
    int lat = 0;
    for (int k = 2; k <= 7; k++) begin
      step();
      if (lat == 0 && resp_valid) begin
        lat = k;
        check({tag, "_rdata"}, resp_rdata, exp_d);
        check({tag, "_err"}, 64'(resp_err), 64'(exp_e));
      end
    end
    check({tag, "_resp_present"}, 64'(lat != 0), 64'(exp_resp));
    if (exp_resp) check({tag, "_latency"}, 64'(lat), 64'd3);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    check({tag, "_init_done"}, 64'(init_done), 64'd0);
    check({tag, "_ren_wen"}, {62'd0, sram_ren, sram_wen}, 64'd0);
    check({tag, "_adr"}, 64'(sram_adr), 64'd0);
    check({tag, "_din"}, sram_din, 64'd0);
    check({tag, "_wbeb"}, sram_wbeb, '1);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < int'(DEP) + 20) begin step(); n++; end
    check({tag, "_init_latency"}, 64'(n), 64'(InitLat));
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          exp_wen;
    logic          exp_ren;
    logic [DW-1:0] exp_wbeb;
    logic          exp_resp;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [DW-1:0] ones = '1;
    logic [DW-1:0] final5;
    int acc, rx, drops, first_c, last_c, ghosts, a;
    bit took;

    vecs[0]  = '{1'b1, 10'd5,   64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 10'd5,   64'h0, 8'h00, 1'b0, 1'b1, ones, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[2]  = '{1'b1, 10'd7,   64'h11111111_11111111, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[3]  = '{1'b1, 10'd7,   ones, 8'h0F, 1'b1, 1'b0, 64'hFFFFFFFF_00000000, 1'b0, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 10'd7,   64'h0, 8'h00, 1'b0, 1'b1, ones, 1'b1, 64'h11111111_FFFFFFFF, 1'b0};
    vecs[5]  = '{1'b1, 10'd600, 64'h1234, 8'hFF, 1'b0, 1'b0, ones, 1'b0, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 10'd600, 64'h0, 8'h00, 1'b0, 1'b0, ones, 1'b1, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 10'd511, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[8]  = '{1'b0, 10'd511, 64'h0, 8'h00, 1'b0, 1'b1, ones, 1'b1, 64'hA5A5A5A5_5A5A5A5A, 1'b0};
    vecs[9]  = '{1'b1, 10'd5,   64'h0, 8'h3C, 1'b1, 1'b0, 64'hFFFF0000_0000FFFF, 1'b0, 64'h0, 1'b0};
    vecs[10] = '{1'b0, 10'd5,   64'h0, 8'h00, 1'b0, 1'b1, ones, 1'b1, 64'hDEAD0000_0000F00D, 1'b0};

    rst = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    n_req_valid = 1'b0; n_req_write = 1'b0; n_req_addr = '0; n_req_wdata = '0; n_req_wmask = '0;
    step(); step(); step();
    check_reset_state("por");
    check("static_pins", {50'd0, sram_mcen, sram_mc, sram_wa, sram_wpulse, sram_wpulseen,
                          sram_fwen, sram_clkbyp, n_mcen, n_mc}, 64'd0);
    rst = 1'b0;
    wait_init("por");

    // Partial top lane on the 44-bit instance: mask bit 5 covers bits 43:40 only.
    n_req_valid = 1'b1; n_req_write = 1'b1; n_req_addr = 4'd3;
    n_req_wdata = 44'hABC_DEF0_1234; n_req_wmask = 6'b100000;
    check("narrow_req_ready", 64'(n_req_ready), 64'd1);
    step();
    n_req_valid = 1'b0;
    check("narrow_wen", 64'(n_sram_wen), 64'd1);
    check("narrow_wbeb", 64'(n_sram_wbeb), 64'h0FF_FFFF_FFFF);
    check("narrow_din", 64'(n_sram_din), 64'hABC_DEF0_1234);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      check($sformatf("v%0d_wen", i), 64'(sram_wen), 64'(vecs[i].exp_wen));
      check($sformatf("v%0d_ren", i), 64'(sram_ren), 64'(vecs[i].exp_ren));
      check($sformatf("v%0d_wbeb", i), sram_wbeb, vecs[i].exp_wbeb);
      if (vecs[i].exp_wen || vecs[i].exp_ren)
        check($sformatf("v%0d_adr", i), 64'(sram_adr), 64'(vecs[i].addr));
      if (vecs[i].exp_wen) check($sformatf("v%0d_din", i), sram_din, vecs[i].wdata);
      await_resp($sformatf("v%0d", i), vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back writes then reads of 0..15 with resp_ready high.
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(i); req_wdata = pat(i);
      req_wmask = 8'hFF;
      if (!req_ready) drops++;
      step();
    end
    req_valid = 1'b0;
    rx = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (resp_valid) begin
        check($sformatf("b2b_data%0d", rx), resp_rdata, pat(rx));
        if (first_c < 0) first_c = c;
        last_c = c;
        rx++;
      end
      if (c < 16) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(c);
        if (!req_ready) drops++;
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    check("b2b_ready_drops", 64'(drops), 64'd0);
    check("b2b_count", 64'(rx), 64'd16);
    check("b2b_spacing", 64'(last_c - first_c), 64'd15);

    // Backpressure: exactly RESP_DEPTH reads accepted, then drained without loss.
    resp_ready = 1'b0; acc = 0; a = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a);
      took = req_ready;
      if (took) acc++;
      step();
      if (took) a++;
    end
    check("bp_accepted", 64'(acc), 64'(RD));
    check("bp_ready_low", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    rx = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) begin
        check($sformatf("bp_data%0d", rx), resp_rdata, pat(rx));
        rx++;
      end
      step();
    end
    check("bp_drained", 64'(rx), 64'(RD));

    // Reset with two reads in flight: no responses may emerge afterwards.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd1;
    step();
    req_addr = 10'd2;
    step();
    req_valid = 1'b0; rst = 1'b1;
    step();
    check_reset_state("midrst");
    rst = 1'b0;
    ghosts = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) ghosts++;
      step();
    end
    check("midrst_ghost_resp", 64'(ghosts), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init("rerst");

`ifdef SRAM_PORT_INIT_EN
    final5 = '0;
`else
    final5 = pat(5);
`endif
    issue(1'b0, 10'd5, 64'h0, 8'h00);
    await_resp("final", 1'b1, final5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
